// File: rtl/rx_pbm_ingress.sv
// Store-and-forward ingress stage: validates AXI-Stream frames and forwards only committed good frames to the PBM write port.
// Optional frame statistics counters are enabled by defining RX_INGRESS_STATS_EN.
module rx_pbm_ingress #(
    parameter int DEPTH_LOG2    = 9,
    parameter int MAX_PKT_BYTES = 2048,
    parameter int MIN_PKT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic        rx_wr_valid,
    output logic [31:0] rx_wr_data,
    output logic        rx_wr_last,
    input  logic        rx_wr_ready,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DROP  = 2'd2
    } state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] k);
        popcount4 = 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, b};
        sat_add16 = s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic last_keep_ok(input logic [3:0] k);
        case (k)
            4'h1, 4'h3, 4'h7, 4'hF: last_keep_ok = 1'b1;
            default:                last_keep_ok = 1'b0;
        endcase
    endfunction

    logic [32:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_r, wr_commit_r, rd_ptr_r;
    state_t        state_r, state_s;
    logic [15:0]   byte_cnt_r, byte_cnt_s;
    logic          err_r, err_s;
    logic          ready_r;
    logic          beat_s, full_s, keep_bad_s;
    logic          wr_en_s, commit_s, rollback_s, load_s;
    logic [32:0]   rd_word_s;
    logic          out_valid_r, out_last_r;
    logic [31:0]   out_data_r;

    assign s_axis_tready = ready_r;
    assign beat_s        = s_axis_tvalid & ready_r;
    // Full is judged against rd_ptr before this cycle's read, so committed words are never overwritten.
    assign full_s        = (wr_ptr_r - rd_ptr_r) == PW'(DEPTH);
    assign keep_bad_s    = s_axis_tlast ? ~last_keep_ok(s_axis_tkeep) : (s_axis_tkeep != 4'hF);
    assign load_s        = (~out_valid_r | rx_wr_ready) & (rd_ptr_r != wr_commit_r);
    assign rd_word_s     = mem[rd_ptr_r[DEPTH_LOG2-1:0]];

    // Write FSM next-state: validate each beat and decide commit or rollback on tlast.
    always_comb begin
        state_s    = state_r;
        byte_cnt_s = byte_cnt_r;
        err_s      = err_r;
        wr_en_s    = 1'b0;
        commit_s   = 1'b0;
        rollback_s = 1'b0;
        case (state_r)
            IDLE, ACCUM: begin
                if (beat_s) begin
                    byte_cnt_s = sat_add16((state_r == IDLE) ? 16'd0 : byte_cnt_r,
                                           popcount4(s_axis_tkeep));
                    err_s      = ((state_r == ACCUM) & err_r) | s_axis_tuser | keep_bad_s | full_s
                                 | (byte_cnt_s > 16'(MAX_PKT_BYTES));
                    wr_en_s    = ~full_s;
                    if (s_axis_tlast) begin
                        state_s = IDLE;
                        if (!err_s && (byte_cnt_s >= 16'(MIN_PKT_BYTES))) begin
                            commit_s = 1'b1;
                        end else begin
                            rollback_s = 1'b1;
                        end
                    end else if (err_s) begin
                        state_s = DROP;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            DROP: begin
                if (beat_s && s_axis_tlast) begin
                    state_s    = IDLE;
                    rollback_s = 1'b1;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, frame accounting and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            byte_cnt_r  <= 16'd0;
            err_r       <= 1'b0;
            ready_r     <= 1'b0;
            wr_ptr_r    <= '0;
            wr_commit_r <= '0;
            rd_ptr_r    <= '0;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            err_r      <= err_s;
            ready_r    <= 1'b1;
            if (rollback_s) begin
                wr_ptr_r <= wr_commit_r;
            end else if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (commit_s) begin
                wr_commit_r <= wr_ptr_r + PW'(1);
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Frame storage; contents beyond wr_commit are speculative and never read.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem[wr_ptr_r[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // PBM output register: holds while stalled, refills when empty or consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= rd_word_s[32];
            out_data_r  <= rd_word_s[31:0];
        end else if (rx_wr_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign rx_wr_valid = out_valid_r;
    assign rx_wr_data  = out_data_r;
    assign rx_wr_last  = out_last_r;

`ifdef RX_INGRESS_STATS_EN
    logic [15:0] pkt_cnt_r, drop_cnt_r;

    // Saturating forwarded/dropped frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_r  <= 16'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (commit_s && (pkt_cnt_r != 16'hFFFF)) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end
            if (rollback_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_r;
    assign drop_cnt = drop_cnt_r;
`else
    assign pkt_cnt  = 16'h0000;
    assign drop_cnt = 16'h0000;
`endif

endmodule
